// File: rtl/fp_pkg.sv
// ============================================================================
// fp_pkg : rounding-mode encodings, operand class bits and format helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package fp_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rmode_e;

    typedef struct packed {
        logic zero;
        logic inf;
        logic qnan;
        logic snan;
    } fp_class_t;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, all-ones exponent, fraction MSB set.
    function automatic logic [127:0] qnan(input int exp_w, input int frc_w);
        return ((128'd1 << (exp_w + 1)) - 128'd1) << (frc_w - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_mul_round.sv
// ============================================================================
// fp_mul_round : combinational round, overflow/underflow and pack stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module fp_mul_round
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int FRC_W = 23
) (
    input  logic                    [FRC_W:0]       mant,
    input  logic                    [2:0]           grs,
    input  logic signed             [EXP_W+1:0]     exp_n,
    input  logic                                    sign,
    input  logic                    [2:0]           r_mode,
    input  fp_class_t                               cls_x,
    input  fp_class_t                               cls_y,
    output logic                    [EXP_W+FRC_W:0] z,
    output logic                                    ovrf,
    output logic                                    udrf,
    output logic                                    nv
);

    localparam int W = 1 + EXP_W + FRC_W;
    localparam logic [W-1:0]             QNAN_C  = W'(qnan(EXP_W, FRC_W));
    localparam logic signed [EXP_W+1:0]  EXP_MAX = {2'b00, {EXP_W{1'b1}}};
    localparam logic [EXP_W+1:0]         EXP_ONE = {{(EXP_W+1){1'b0}}, 1'b1};

    logic                   inc;
    logic                   to_inf;
    logic                   nan_any;
    logic                   inf_zero;
    logic [FRC_W+1:0]       mant_r;
    logic [FRC_W-1:0]       frac_f;
    logic signed [EXP_W+1:0] exp_r;

    always_comb begin
        inc      = 1'b0;
        to_inf   = 1'b0;
        z        = '0;
        ovrf     = 1'b0;
        udrf     = 1'b0;
        nv       = 1'b0;
        nan_any  = cls_x.qnan | cls_x.snan | cls_y.qnan | cls_y.snan;
        inf_zero = (cls_x.inf & cls_y.zero) | (cls_x.zero & cls_y.inf);

        case (rmode_e'(r_mode))
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (|grs);
            RM_RUP:  inc = ~sign & (|grs);
            RM_RMM:  inc = grs[2];
            default: inc = grs[2] & (grs[1] | grs[0] | mant[0]);
        endcase

        case (rmode_e'(r_mode))
            RM_RTZ:  to_inf = 1'b0;
            RM_RDN:  to_inf = sign;
            RM_RUP:  to_inf = ~sign;
            default: to_inf = 1'b1;
        endcase

        mant_r = {1'b0, mant} + {{(FRC_W+1){1'b0}}, inc};
        if (mant_r[FRC_W+1]) begin
            frac_f = mant_r[FRC_W:1];
            exp_r  = exp_n + EXP_ONE;
        end else begin
            frac_f = mant_r[FRC_W-1:0];
            exp_r  = exp_n;
        end

        // Special operands win over every numeric path.
        if (nan_any || inf_zero) begin
            z  = QNAN_C;
            nv = cls_x.snan | cls_y.snan | inf_zero;
        end else if (cls_x.inf || cls_y.inf) begin
            z = {sign, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
        end else if (cls_x.zero || cls_y.zero) begin
            z = {sign, {(W-1){1'b0}}};
        end else if (exp_n[EXP_W+1] || (exp_n == '0)) begin
            udrf = 1'b1;
            z    = {sign, {(W-1){1'b0}}};
        end else if (exp_r >= EXP_MAX) begin
            ovrf = 1'b1;
            z    = to_inf ? {sign, {EXP_W{1'b1}}, {FRC_W{1'b0}}}
                          : {sign, {(EXP_W-1){1'b1}}, 1'b0, {FRC_W{1'b1}}};
        end else begin
            z = {sign, exp_r[EXP_W-1:0], frac_f};
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_mul_pipe.sv
// ============================================================================
// fp_mul_pipe : 3-stage valid/ready IEEE-754 multiplier (unpack, normalise, round)
// Revision: 1.0
// ============================================================================
`default_nettype none

module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int FRC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRC_W:0]    fp_X,
    input  logic [EXP_W+FRC_W:0]    fp_Y,
    input  logic [2:0]              r_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRC_W:0]    fp_Z,
    output logic                    ovrf,
    output logic                    udrf,
    output logic                    nv
);

    localparam int M = FRC_W + 1;
    localparam int W = 1 + EXP_W + FRC_W;
    localparam logic [EXP_W+1:0] BIAS_C  = (EXP_W+2)'(bias(EXP_W));
    localparam logic [EXP_W+1:0] EXP_ONE = {{(EXP_W+1){1'b0}}, 1'b1};

    function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [FRC_W-1:0] f);
        fp_class_t c;
        c.zero = (e == '0);
        c.inf  = (&e) & (f == '0);
        c.qnan = (&e) & f[FRC_W-1];
        c.snan = (&e) & ~f[FRC_W-1] & (f != '0);
        return c;
    endfunction

    logic ld1, ld2, ld3;

    logic                    s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d;
    logic signed [EXP_W+1:0] s1_exp_q, s1_exp_d;
    logic [2*M-1:0]          s1_prod_q, s1_prod_d;
    fp_class_t               s1_cls_x_q, s1_cls_x_d, s1_cls_y_q, s1_cls_y_d;
    logic [2:0]              s1_rmode_q, s1_rmode_d;

    logic                    s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d;
    logic signed [EXP_W+1:0] s2_exp_q, s2_exp_d;
    logic [FRC_W:0]          s2_mant_q, s2_mant_d;
    logic [2:0]              s2_grs_q, s2_grs_d;
    fp_class_t               s2_cls_x_q, s2_cls_x_d, s2_cls_y_q, s2_cls_y_d;
    logic [2:0]              s2_rmode_q, s2_rmode_d;

    logic                    s3_valid_q, s3_valid_d;
    logic [W-1:0]            fp_z_q, fp_z_d;
    logic                    ovrf_q, ovrf_d, udrf_q, udrf_d, nv_q, nv_d;

    logic [2*M-1:0]          norm_prod;
    logic [W-1:0]            rnd_z;
    logic                    rnd_ovrf, rnd_udrf, rnd_nv;

    always_comb begin
        ld3 = ~s3_valid_q | out_ready;
        ld2 = ~s2_valid_q | ld3;
        ld1 = ~s1_valid_q | ld2;

        s1_valid_d = s1_valid_q;  s1_sign_d  = s1_sign_q;   s1_exp_d   = s1_exp_q;
        s1_prod_d  = s1_prod_q;   s1_cls_x_d = s1_cls_x_q;  s1_cls_y_d = s1_cls_y_q;
        s1_rmode_d = s1_rmode_q;
        s2_valid_d = s2_valid_q;  s2_sign_d  = s2_sign_q;   s2_exp_d   = s2_exp_q;
        s2_mant_d  = s2_mant_q;   s2_grs_d   = s2_grs_q;    s2_cls_x_d = s2_cls_x_q;
        s2_cls_y_d = s2_cls_y_q;  s2_rmode_d = s2_rmode_q;
        s3_valid_d = s3_valid_q;  fp_z_d     = fp_z_q;
        ovrf_d     = ovrf_q;      udrf_d     = udrf_q;      nv_d       = nv_q;
        norm_prod  = s1_prod_q[2*M-1] ? s1_prod_q : (s1_prod_q << 1);

        if (ld1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d  = fp_X[W-1] ^ fp_Y[W-1];
                s1_exp_d   = $signed({2'b00, fp_X[W-2:FRC_W]}) + $signed({2'b00, fp_Y[W-2:FRC_W]})
                           - $signed(BIAS_C);
                s1_prod_d  = {{M{1'b0}}, 1'b1, fp_X[FRC_W-1:0]} * {{M{1'b0}}, 1'b1, fp_Y[FRC_W-1:0]};
                s1_cls_x_d = classify(fp_X[W-2:FRC_W], fp_X[FRC_W-1:0]);
                s1_cls_y_d = classify(fp_Y[W-2:FRC_W], fp_Y[FRC_W-1:0]);
                s1_rmode_d = r_mode;
            end
        end

        if (ld2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_d  = s1_sign_q;
                s2_exp_d   = s1_prod_q[2*M-1] ? (s1_exp_q + $signed(EXP_ONE)) : s1_exp_q;
                s2_mant_d  = norm_prod[2*M-1 -: M];
                s2_grs_d   = {norm_prod[M-1], norm_prod[M-2], |norm_prod[M-3:0]};
                s2_cls_x_d = s1_cls_x_q;
                s2_cls_y_d = s1_cls_y_q;
                s2_rmode_d = s1_rmode_q;
            end
        end

        // Output word only changes when a new beat lands, so it holds under stall.
        if (ld3) begin
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                fp_z_d = rnd_z;
                ovrf_d = rnd_ovrf;
                udrf_d = rnd_udrf;
                nv_d   = rnd_nv;
            end
        end
    end

    fp_mul_round #(
        .EXP_W (EXP_W),
        .FRC_W (FRC_W)
    ) u_round (
        .mant   (s2_mant_q),
        .grs    (s2_grs_q),
        .exp_n  (s2_exp_q),
        .sign   (s2_sign_q),
        .r_mode (s2_rmode_q),
        .cls_x  (s2_cls_x_q),
        .cls_y  (s2_cls_y_q),
        .z      (rnd_z),
        .ovrf   (rnd_ovrf),
        .udrf   (rnd_udrf),
        .nv     (rnd_nv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;  s1_sign_q  <= 1'b0;  s1_exp_q   <= '0;
            s1_prod_q  <= '0;    s1_cls_x_q <= '0;    s1_cls_y_q <= '0;
            s1_rmode_q <= '0;
            s2_valid_q <= 1'b0;  s2_sign_q  <= 1'b0;  s2_exp_q   <= '0;
            s2_mant_q  <= '0;    s2_grs_q   <= '0;    s2_cls_x_q <= '0;
            s2_cls_y_q <= '0;    s2_rmode_q <= '0;
            s3_valid_q <= 1'b0;  fp_z_q     <= '0;
            ovrf_q     <= 1'b0;  udrf_q     <= 1'b0;  nv_q       <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;  s1_sign_q  <= s1_sign_d;   s1_exp_q   <= s1_exp_d;
            s1_prod_q  <= s1_prod_d;   s1_cls_x_q <= s1_cls_x_d;  s1_cls_y_q <= s1_cls_y_d;
            s1_rmode_q <= s1_rmode_d;
            s2_valid_q <= s2_valid_d;  s2_sign_q  <= s2_sign_d;   s2_exp_q   <= s2_exp_d;
            s2_mant_q  <= s2_mant_d;   s2_grs_q   <= s2_grs_d;    s2_cls_x_q <= s2_cls_x_d;
            s2_cls_y_q <= s2_cls_y_d;  s2_rmode_q <= s2_rmode_d;
            s3_valid_q <= s3_valid_d;  fp_z_q     <= fp_z_d;
            ovrf_q     <= ovrf_d;      udrf_q     <= udrf_d;      nv_q       <= nv_d;
        end
    end

    assign in_ready  = ld1;
    assign out_valid = s3_valid_q;
    assign fp_Z      = fp_z_q;
    assign ovrf      = ovrf_q;
    assign udrf      = udrf_q;
    assign nv        = nv_q;

endmodule

`default_nettype wire
